// File: rtl/alu_mc.sv
// alu_mc -- multi-cycle ALU with registered outputs and status flags.
//
// Single-cycle ops (ADD, SUB, AND, OR, XOR, SLT) are computed from the
// live inputs and registered on the start edge. MULU (shift-add) and DIVU
// (restoring) iterate one bit per cycle for WIDTH cycles and then publish
// their results from the FIN state. All result fields and flags change
// only together with the one-cycle done pulse.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset (aborts any operation)
//   start        operation request, sampled only in IDLE
//   op           3-bit operation select
//   a, b         operands, captured on the start edge
//   busy         multi-cycle operation in progress (start ignored)
//   done         one-cycle pulse, result fields valid
//   result       primary result / MUL low half / DIV quotient
//   result_hi    MUL high half / DIV remainder, 0 for other ops
//   zero         result == 0
//   overflow     signed overflow for ADD/SUB
//   div_by_zero  DIVU with b == 0
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_MULU = 3'b110;
  localparam logic [2:0] OP_DIVU = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t           state;
  // Multiplicand for MUL, divisor for DIV.
  logic [WIDTH-1:0] operand_reg;
  // Working pair: MUL {partial product high, multiplier/product low};
  // DIV {partial remainder, dividend/quotient}.
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [CNT_W-1:0] cnt_reg;

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             slt;

  assign sum  = a + b;
  assign diff = a - b;
  assign slt  = ($signed(a) < $signed(b));

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      default: alu_res = '0;
    endcase
  end

  // ---------------- shift-add multiply step ----------------
  // Add the multiplicand when the current multiplier LSB is set, then shift
  // the whole {carry, hi, lo} right by one; the product builds up in hi:lo.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;

  assign mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, operand_reg} : '0);
  assign mul_hi_next = mul_sum[WIDTH:1];
  assign mul_lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};

  // ---------------- restoring divide step ----------------
  // Shift the next dividend bit into the remainder; if the divisor fits,
  // subtract it and shift a 1 into the quotient. The partial remainder is
  // always below the divisor, so the shifted value fits in WIDTH+1 bits and
  // the difference fits back into WIDTH bits.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_next;
  logic [WIDTH-1:0] div_lo_next;

  assign div_shift   = {hi_reg, lo_reg[WIDTH-1]};
  assign div_ge      = (div_shift >= {1'b0, operand_reg});
  assign div_sub     = div_shift - {1'b0, operand_reg};
  assign div_hi_next = div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_lo_next = {lo_reg[WIDTH-2:0], div_ge};

  // ---------------- control FSM with registered outputs ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      operand_reg <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      cnt_reg     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULU: begin
                state       <= MUL;
                busy        <= 1'b1;
                operand_reg <= a;
                hi_reg      <= '0;
                lo_reg      <= b;
                cnt_reg     <= '0;
              end
              OP_DIVU: begin
                if (b == '0) begin
                  // Divide by zero completes immediately with a fixed result.
                  done        <= 1'b1;
                  result      <= '1;
                  result_hi   <= a;
                  zero        <= 1'b0;
                  overflow    <= 1'b0;
                  div_by_zero <= 1'b1;
                end else begin
                  state       <= DIV;
                  busy        <= 1'b1;
                  operand_reg <= b;
                  hi_reg      <= '0;
                  lo_reg      <= a;
                  cnt_reg     <= '0;
                end
              end
              default: begin
                done        <= 1'b1;
                result      <= alu_res;
                result_hi   <= '0;
                zero        <= (alu_res == '0);
                overflow    <= alu_ovf;
                div_by_zero <= 1'b0;
              end
            endcase
          end
        end

        MUL: begin
          hi_reg  <= mul_hi_next;
          lo_reg  <= mul_lo_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) state <= FIN;
        end

        DIV: begin
          hi_reg  <= div_hi_next;
          lo_reg  <= div_lo_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) state <= FIN;
        end

        FIN: begin
          // busy drops on the same edge that raises done, so they never overlap.
          state       <= IDLE;
          busy        <= 1'b0;
          done        <= 1'b1;
          result      <= lo_reg;
          result_hi   <= hi_reg;
          zero        <= (lo_reg == '0);
          overflow    <= 1'b0;
          div_by_zero <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
